// File: rtl/ram_readback_control.sv
// ram_readback_control
//
// Reads back DEPTH words from the on-chip RAM (addresses 0..DEPTH-1),
// presents each word on a registered output stream with its index and
// accumulates a modular checksum of the words.
//
// Handshake: start_sig is a level request. A run begins at the first edge
// where start_sig is high in IDLE and continues only while start_sig stays
// high. Dropping start_sig during READ or DRAIN aborts the run (no done_sig).
// A completed run pulses done_sig for exactly one cycle, then the block
// waits for start_sig to go low before it can be started again.
// dout/dout_index are qualified by dout_valid and hold their value otherwise.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start_sig  level run request
//   done_sig   one-cycle completion pulse
//   read_en    RAM read enable
//   ram_addr   RAM read address
//   ram_data   RAM read data, valid RD_LAT cycles after its address
//   dout       registered read word
//   dout_index address that dout came from
//   dout_valid dout/dout_index valid this cycle
//   checksum   sum of captured words mod 2^DATA_W
//   fsm_state  current FSM state (debug visibility)

module ram_readback_control #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_sig,
   output logic              done_sig,
   output logic              read_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] dout,
   output logic [ADDR_W-1:0] dout_index,
   output logic              dout_valid,
   output logic [DATA_W-1:0] checksum,
   output logic [2:0]        fsm_state
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_READ     = 3'd1;
   localparam logic [2:0] S_DRAIN    = 3'd2;
   localparam logic [2:0] S_DONE     = 3'd3;
   localparam logic [2:0] S_WAIT_LOW = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [2:0]        state;
   logic [RD_LAT-1:0] pipe_v;
   logic [ADDR_W-1:0] pipe_a [RD_LAT];
   logic              tail_v;
   logic [ADDR_W-1:0] tail_a;
   logic              abort;

   assign fsm_state = state;
   assign tail_v    = pipe_v[RD_LAT-1];
   assign tail_a    = pipe_a[RD_LAT-1];
   assign abort     = !start_sig && (state == S_READ || state == S_DRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         done_sig   <= 1'b0;
         read_en    <= 1'b0;
         ram_addr   <= '0;
         dout       <= '0;
         dout_index <= '0;
         dout_valid <= 1'b0;
         checksum   <= '0;
         pipe_v     <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_a[i] <= '0;
      end else begin
         // (valid, addr) shift that mirrors the RAM read latency; an abort
         // flushes any reads still in flight so nothing is emitted later.
         if (abort) begin
            pipe_v <= '0;
         end else begin
            pipe_v[0] <= read_en;
            for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
         end
         pipe_a[0] <= ram_addr;
         for (int i = 1; i < RD_LAT; i++) pipe_a[i] <= pipe_a[i-1];

         dout_valid <= 1'b0;
         if (tail_v && !abort) begin
            dout       <= ram_data;
            dout_index <= tail_a;
            dout_valid <= 1'b1;
            checksum   <= checksum + ram_data;
         end

         done_sig <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start_sig) begin
                  state    <= S_READ;
                  read_en  <= 1'b1;
                  ram_addr <= '0;
                  checksum <= '0;
               end
            end
            S_READ: begin
               if (abort) begin
                  state    <= S_IDLE;
                  read_en  <= 1'b0;
                  ram_addr <= '0;
               end else if (ram_addr == LAST_ADDR) begin
                  state    <= S_DRAIN;
                  read_en  <= 1'b0;
                  ram_addr <= '0;
               end else begin
                  ram_addr <= ram_addr + 1'b1;
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (dout_valid && dout_index == LAST_ADDR) begin
                  // Last word is on dout this cycle; done follows next cycle.
                  state    <= S_DONE;
                  done_sig <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               if (!start_sig) state <= S_IDLE;
            end
            default: begin
               state   <= S_IDLE;
               read_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ram_readback_control.md
Name: ram_readback_control

Overview:
- Sequencer that reads back the DEPTH words the copy sequencer writes into the on-chip RAM, walking addresses 0..DEPTH-1.
- Presents each word on a registered output stream with its index.
- Accumulates a modular checksum of the words.
- Uses the same start_sig/done_sig handshake as the other control modules; sits between the RAM read port and downstream display/check logic.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 16, words to read; 1 <= DEPTH <= 2^ADDR_W.
- RD_LAT, 1, RAM read latency in cycles from address to ram_data; range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start_sig  in  1  level request; the run proceeds while high.
- done_sig  out  1  one-cycle pulse when the run completes.
- read_en  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM read address.
- ram_data  in  DATA_W  RAM read data, valid RD_LAT cycles after its address.
- dout  out  DATA_W  registered read word.
- dout_index  out  ADDR_W  address that dout came from.
- dout_valid  out  1  dout/dout_index valid this cycle.
- checksum  out  DATA_W  sum of all words mod 2^DATA_W; stable from the done_sig cycle until the next run starts.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n low at a clk edge): all outputs 0, state IDLE, pipeline cleared. Reset overrides every other condition, including mid-run.
- All outputs are registered.
- FSM states: IDLE, READ, DRAIN, DONE, WAIT_LOW.
- IDLE: at an edge with start_sig=1, go to READ, clear checksum and counters.
- READ: read_en=1, ram_addr=0,1,...,DEPTH-1 on consecutive cycles, exactly DEPTH cycles, no gaps. After the cycle with address DEPTH-1, go to DRAIN with read_en=0 and ram_addr=0. ram_addr never exceeds DEPTH-1 and never wraps.
- Latency pipeline: a RD_LAT-deep shift of (valid, addr) follows read_en. When the pipeline tail is valid in cycle k+RD_LAT, ram_data is captured. Captured values appear in cycle k+RD_LAT+1 as dout, dout_index=address, dout_valid=1. checksum is updated in the same edge: checksum <= checksum + ram_data, truncated to DATA_W.
- dout and dout_index hold their last values when dout_valid=0.
- DRAIN: stay until the last word has been emitted (dout_valid high for index DEPTH-1), then go to DONE.
- DONE: done_sig=1 for exactly one cycle, i.e. the cycle after the last dout_valid. Then go to WAIT_LOW.
- WAIT_LOW: wait for start_sig=0, then go to IDLE. A held-high start_sig never retriggers a run.
- Abort: start_sig=0 at any edge in READ or DRAIN forces IDLE next cycle. read_en, dout_valid and pipeline valids go 0. No done_sig is issued. checksum holds its partial value.
- Total timing with start seen at edge 0:
  - read_en in cycles 1..DEPTH
  - dout_valid in cycles RD_LAT+2 .. DEPTH+RD_LAT+1
  - done_sig in cycle DEPTH+RD_LAT+2
- DEPTH=1 is legal: a single read, a single dout_valid, then done.

Test Plan:
- Reset then idle, start_sig=0 for 10 cycles -> all outputs 0, read_en never asserts.
- RAM preloaded with word[i]=i+1 (DEPTH=16, RD_LAT=1); start_sig rises at edge 0 and is held -> read_en cycles 1..16 with addr 0..15; dout_valid cycles 3..18 with dout=1..16 and index 0..15; done_sig only in cycle 19; checksum=136 (0x88); no second run while start stays high.
- Same data with RD_LAT=3 -> dout_valid cycles 5..20, done_sig in cycle 21, checksum 0x88.
- All words 0xFF, DEPTH=16 -> checksum wraps to 0xF0; dout_valid has no gaps.
- start_sig dropped in cycle 6 of READ -> read_en=0 next cycle, no done_sig, FSM in IDLE. Raising start again gives a full run from addr 0 with checksum recomputed from 0.
- rst_n low for one edge during DRAIN -> next cycle all outputs 0 and FSM IDLE. A later start gives a correct complete run.
